// File: rtl/inst_fetch_buffer.sv
// RV32I fetch: sequential PC, in-order imem requests, DEPTH-entry buffer to decode. Latency req->id_valid = k+1 cycles.
// Requests stall when allocated+stale reaches DEPTH; decode back-pressure holds the head; redirect flushes and drops stale responses.
module inst_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CW-1:0] alloc_q, alloc_d, drop_q, drop_d, unfill_q, unfill_d;

  logic [31:0]      ent_pc_q   [DEPTH];
  logic [31:0]      ent_inst_q [DEPTH];
  logic [DEPTH-1:0] ent_filled_q;

  logic        req_fire, deq_fire, rsp_drop, rsp_fill, rsp_any;
  logic [CW:0] occ;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Stale in-flight responses still occupy memory-side slots, so they count against capacity.
  assign occ            = {1'b0, alloc_q} + {1'b0, drop_q};
  assign imem_req_valid = !redirect_valid && (occ < DEPTH_W);
  assign imem_req_addr  = pc_q;

  assign id_valid = ent_filled_q[head_q] && !redirect_valid;
  assign id_inst  = ent_inst_q[head_q];
  assign id_pc    = ent_pc_q[head_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign deq_fire = id_valid && id_ready;
  assign rsp_any  = imem_rsp_valid && ((drop_q != '0) || (unfill_q != '0));
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (unfill_q != '0);

  always_comb begin
    pc_d     = pc_q;
    head_d   = head_q;
    fill_d   = fill_q;
    tail_d   = tail_q;
    alloc_d  = alloc_q;
    drop_d   = drop_q;
    unfill_d = unfill_q;
    if (redirect_valid) begin
      head_d   = tail_q;
      fill_d   = tail_q;
      alloc_d  = '0;
      unfill_d = '0;
      // A response arriving in the redirect cycle is itself one of the discarded ones.
      drop_d   = drop_q + unfill_q - CW'(rsp_any);
      pc_d     = {redirect_pc[31:2], 2'b00};
    end else begin
      if (req_fire) begin
        tail_d = tail_q + AW'(1);
        pc_d   = pc_q + 32'd4;
      end
      if (deq_fire) head_d = head_q + AW'(1);
      if (rsp_fill) fill_d = fill_q + AW'(1);
      alloc_d  = alloc_q + CW'(req_fire) - CW'(deq_fire);
      unfill_d = unfill_q + CW'(req_fire) - CW'(rsp_fill);
      drop_d   = drop_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      alloc_q  <= '0;
      drop_q   <= '0;
      unfill_q <= '0;
    end else begin
      pc_q     <= pc_d;
      head_q   <= head_d;
      fill_q   <= fill_d;
      tail_q   <= tail_d;
      alloc_q  <= alloc_d;
      drop_q   <= drop_d;
      unfill_q <= unfill_d;
    end
  end

  // Tail, fill and head never alias in one cycle: tail is free, fill is unfilled, head is filled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= '0;
        ent_inst_q[i] <= '0;
      end
      ent_filled_q <= '0;
    end else if (redirect_valid) begin
      ent_filled_q <= '0;
    end else begin
      if (req_fire) begin
        ent_pc_q[tail_q]     <= pc_q;
        ent_filled_q[tail_q] <= 1'b0;
      end
      if (rsp_fill) begin
        ent_inst_q[fill_q]   <= imem_rsp_data;
        ent_filled_q[fill_q] <= 1'b1;
      end
      if (deq_fire) ent_filled_q[head_q] <= 1'b0;
    end
  end

  a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rstn)
    imem_rsp_valid |-> ((drop_q != '0) || (unfill_q != '0)));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: queue-based reference model plus directed pins and randomized traffic.
module tb_inst_fetch_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  inst_fetch_buffer #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } rdy_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  out_t        outst[$];     // requests issued, response not yet returned
  rdy_t        rdy[$];       // instructions waiting for decode
  mem_t        mem_q[$];     // memory-side view of accepted requests
  logic [31:0] delivered[$];
  logic [31:0] mpc;
  bit          exp_req_valid, exp_id_valid, dut_fire;
  logic [31:0] dut_addr;
  int          n_cmp = 0, n_fail = 0;
  int          cyc, phase, kval;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (phase %0d cycle %0d)", name, act, exp, phase, cyc);
    end
  endtask

  task automatic model_reset();
    outst.delete();
    rdy.delete();
    mem_q.delete();
    delivered.delete();
    mpc = RPC;
  endtask

  task automatic drive_inputs();
    case (phase)
      1: begin imem_req_ready = 1'b1; id_ready = !(cyc >= 3 && cyc < 8); redirect_valid = 1'b0;
               redirect_pc = '0; kval = 1; end
      2: begin imem_req_ready = 1'b1; id_ready = 1'b1; redirect_valid = (cyc == 2);
               redirect_pc = 32'h0000_0100; kval = 3; end
      3: begin imem_req_ready = 1'b1; id_ready = 1'b1; redirect_valid = (cyc == 1);
               redirect_pc = 32'h0000_0100; kval = 1; end
      4: begin imem_req_ready = cyc[0]; id_ready = 1'b1; redirect_valid = (cyc == 0);
               redirect_pc = 32'hFFFF_FFF8; kval = 1; end
      default: begin
        imem_req_ready = ($urandom % 100) < 70;
        id_ready       = (phase == 7) ? (($urandom % 100) < 30) : (($urandom % 100) < 75);
        redirect_valid = ($urandom % 100) < 4;
        redirect_pc    = $urandom;
        kval           = $urandom_range(1, 4);
      end
    endcase
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(mem_q[0].addr);
      end
    end
  endtask

  // Output comparison against the model, sampled mid-cycle.
  task automatic eval_check();
    exp_req_valid = !redirect_valid && ((rdy.size() + outst.size()) < DEPTH);
    exp_id_valid  = (rdy.size() > 0) && !redirect_valid;
    check("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
    check("req_addr", imem_req_addr, mpc);
    check("id_valid", 32'(id_valid), 32'(exp_id_valid));
    if (exp_id_valid) begin
      check("id_pc", id_pc, rdy[0].pc);
      check("id_inst", id_inst, rdy[0].inst);
    end
    dut_fire = imem_req_valid && imem_req_ready;
    dut_addr = imem_req_addr;
    if (id_valid && id_ready) delivered.push_back(id_pc);
    case (phase)
      1: begin
        if (cyc == 0) check("p1_addr0", imem_req_addr, 32'h0);
        if (cyc == 1) check("p1_idv_c1", 32'(id_valid), 32'h0);
        if (cyc == 2) begin
          check("p1_first_vld", 32'(id_valid), 32'h1);
          check("p1_first_pc", id_pc, 32'h0);
        end
        if (cyc == 3) check("p1_pc_c3", id_pc, 32'h4);
        if (cyc == 5) check("p1_stall_full", 32'(imem_req_valid), 32'h0);
        if (cyc == 6) check("p1_held_inst", id_inst, memf(32'h4));
      end
      2: begin
        if (cyc == 6) check("p2_idv_c6", 32'(id_valid), 32'h0);
        if (cyc == 7) begin
          check("p2_first_vld", 32'(id_valid), 32'h1);
          check("p2_first_pc", id_pc, 32'h100);
        end
      end
      3: begin
        if (cyc == 3) check("p3_idv_c3", 32'(id_valid), 32'h0);
        if (cyc == 4) begin
          check("p3_first_vld", 32'(id_valid), 32'h1);
          check("p3_first_pc", id_pc, 32'h100);
        end
      end
      default: ;
    endcase
  endtask

  task automatic update();
    bit   deq, req;
    out_t o;
    mem_t m;
    deq = exp_id_valid && id_ready;
    req = exp_req_valid && imem_req_ready;
    if (redirect_valid) begin
      if (imem_rsp_valid && outst.size() > 0) void'(outst.pop_front());
      foreach (outst[i]) outst[i].stale = 1'b1;
      rdy.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (deq) void'(rdy.pop_front());
      if (imem_rsp_valid && outst.size() > 0) begin
        o = outst.pop_front();
        if (!o.stale) rdy.push_back('{pc: o.pc, inst: memf(o.pc)});
      end
      if (req) begin
        outst.push_back('{pc: mpc, stale: 1'b0});
        mpc = mpc + 32'd4;
      end
    end
    if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (dut_fire) begin
      m.addr = dut_addr;
      m.due  = cyc + kval;
      mem_q.push_back(m);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_inputs();
      @(negedge clk);
      eval_check();
      @(posedge clk);
      update();
      cyc++;
      #1;
    end
  endtask

  task automatic zero_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_req_valid", 32'(imem_req_valid), 32'h1);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc  = 0;
  endtask

  initial begin
    zero_inputs();
    cyc = 0;
    phase = 1; do_reset(); run(16);
    phase = 2; do_reset(); run(14);
    phase = 3; do_reset(); run(10);
    phase = 4; do_reset(); run(16);
    check("p4_count", 32'(delivered.size() >= 3), 32'h1);
    if (delivered.size() >= 3) begin
      check("p4_seq0", delivered[0], 32'hFFFF_FFF8);
      check("p4_seq1", delivered[1], 32'hFFFF_FFFC);
      check("p4_seq2", delivered[2], 32'h0000_0000);
    end
    phase = 5; do_reset(); run(40);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    zero_inputs();
    #1;
    check("async_id_valid", 32'(id_valid), 32'h0);
    check("async_req_addr", imem_req_addr, RPC);
    check("async_req_valid", 32'(imem_req_valid), 32'h1);
    phase = 6; do_reset(); run(3000);
    phase = 7; do_reset(); run(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Instruction fetch stage of the in-order RV32I core. Generates the sequential PC, issues word fetches to instruction memory over a valid/ready request channel, and collects in-order responses in a small reorder-free buffer. It presents one `{pc, inst}` pair per handshake to decode, where the instruction feeds the immediate generator and control decode. Branch/jump redirects from execute flush the buffer and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, 4: buffer entries, which is also the maximum number of outstanding fetches. Must be a power of 2 and ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address; equals the current PC.
- `imem_rsp_valid` in 1: response data valid. There is no back-pressure. Responses return in request order, ≥1 cycle after acceptance.
- `imem_rsp_data` in 32: fetched instruction word.
- `id_valid` out 1: head entry holds an instruction for decode.
- `id_inst` out 32: head instruction.
- `id_pc` out 32: PC of the head instruction.
- `id_ready` in 1: decode accepts the head entry.
- `redirect_valid` in 1: control-flow redirect from execute.
- `redirect_pc` in 32: redirect target. Bits [1:0] are ignored and treated as 0.

## Operation
- **State**
  - `pc` register.
  - Circular buffer of DEPTH entries `{pc, inst, filled}` with head, fill and tail pointers.
  - `alloc_cnt` (0..DEPTH): entries allocated.
  - `drop_cnt` (0..DEPTH): stale responses still to discard.
- **Request**
  - `imem_req_valid = !redirect_valid && (alloc_cnt + drop_cnt < DEPTH)`.
  - On acceptance (`imem_req_valid && imem_req_ready`): allocate the tail entry with `pc`, `filled=0`; tail++; `pc <= pc + 4`.
  - PC arithmetic is mod 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- **Response**
  - If `drop_cnt > 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: write `imem_rsp_data` into the fill entry, set `filled=1`, fill++.
  - A response with nothing outstanding is a protocol violation. It is ignored and flagged by a simulation assertion.
- **Dequeue**
  - `id_valid = head.filled && !redirect_valid`. `id_inst`/`id_pc` come from the head entry.
  - On `id_valid && id_ready`: clear the head entry, head++, `alloc_cnt--`.
- **Redirect** (`redirect_valid=1`), applied at the edge:
  - Clear all entries and set head = fill = tail.
  - `alloc_cnt <= 0`.
  - `drop_cnt <= drop_cnt + (allocated-but-unfilled entries) - (imem_rsp_valid ? 1 : 0)`. This counts a same-cycle response as already discarded.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No request is issued and no dequeue occurs in the redirect cycle.
- **Reset values**
  - `pc=RESET_PC`; all entries empty; `alloc_cnt=0`, `drop_cnt=0`.
  - Outputs: `id_valid=0`, `id_inst=0`, `id_pc=0`, `imem_req_addr=RESET_PC`, `imem_req_valid=1` (combinational from reset state).
  - Reset asserted mid-operation discards everything immediately. The memory side must also be reset; responses for pre-reset requests are not tracked.

## Timing
- Latency: request accepted at cycle t, response at t+k (k≥1), `id_valid` at t+k+1. There is no response-to-decode bypass.
- Capacity uses registered counts only; a dequeue frees a slot for requests on the next cycle.
  - With k=1, each entry is occupied for 3 cycles.
  - DEPTH=4 sustains 1 instruction/cycle; DEPTH=2 sustains 2 per 3 cycles.
- After redirect at cycle r: the first request to the target is issued at r+1, and the earliest target instruction reaches `id_valid` at r+3 (k=1).
- Simultaneous events in one cycle:
  - Request + response + dequeue: all apply; `alloc_cnt` changes by +1-1.
  - Redirect takes precedence over all of them.
- `imem_req_addr` and `imem_req_valid` must stay stable while `imem_req_ready=0`, except when a redirect occurs.

## Test plan
- **Reset + straight-line fetch.** k=1, `imem_req_ready=1`, `id_ready=1`, RESET_PC=0 → addresses 0,4,8,…, one per cycle. First `id_valid` in cycle 2 with `id_pc=0`; then one instruction per cycle in order.
- **Decode stall.** Hold `id_ready=0` from cycle 3 → after 4 allocations `imem_req_valid=0`. `id_inst` is held. On release, instructions continue with no loss or duplication.
- **Redirect with 2 in flight.** k=3; redirect to 0x0000_0100 while `drop_cnt=0` and 2 entries are unfilled → `drop_cnt=2`. The next two responses are discarded. The first delivered `id_pc` is 0x100.
- **Redirect coinciding with a response.** `redirect_valid` and `imem_rsp_valid` in the same cycle with 1 unfilled entry → `drop_cnt` stays 0 and the next response fills a 0x100 entry.
- **Memory back-pressure and wrap.** RESET_PC=0xFFFF_FFF8, `imem_req_ready` toggling → `imem_req_addr` is held while not ready. The sequence FFF8, FFFC, 0000_0000 is delivered in order.
- **Async reset mid-stream.** `rstn` low in the middle of a cycle → `id_valid=0` and `imem_req_addr=RESET_PC` immediately, without waiting for a clock edge.
